// File: rtl/mem_arb_pkg.sv
// Shared constants and helpers for the N-channel memory port arbiter/mux.
// Imported by the interface, the arbiter and the top level.
package mem_arb_pkg;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  function automatic int clog2_nch(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int lane_lo(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/mem_port_arb_mux_if.sv
// Requester-side and downstream-side handshake bundle of the shared port.
// master drives requests and out_ready; slave is the arbiter/mux side.
interface mem_port_arb_mux_if
  import mem_arb_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NCH   = 4,
  parameter int SELW  = clog2_nch(NCH)
);

  logic [NCH-1:0]       in_valid;
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_ready;
  logic                 out_valid;
  logic [WIDTH-1:0]     out_data;
  logic [SELW-1:0]      out_sel;
  logic                 out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin / fixed-priority grant with a search pointer that
// advances past the winner only when the grant is actually taken.
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int SELW    = clog2_nch(NCH),
  parameter int RR_MODE = ARB_RR
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NCH-1:0]  req,
  input  logic            take,
  output logic [NCH-1:0]  gnt,
  output logic [SELW-1:0] gnt_idx
);

  logic [SELW-1:0] ptr_q, ptr_d;

  // In fixed mode the pointer stays 0, so the same search
  // degenerates to lowest-index-wins.
  always_comb begin
    int   j;
    logic found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    j       = 0;
    for (int k = 0; k < NCH; k++) begin
      j = int'(ptr_q) + k;
      if (j >= NCH) j = j - NCH;
      if (!found && req[j]) begin
        found   = 1'b1;
        gnt[j]  = 1'b1;
        gnt_idx = SELW'(j);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (RR_MODE == ARB_RR && take) begin
      ptr_d = (gnt_idx == SELW'(NCH - 1)) ? '0
                                          : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mem_port_arb_mux.sv
// N-channel arbiter feeding one registered output stage of the shared
// memory port; refills on the same edge the held word is accepted.
module mem_port_arb_mux
  import mem_arb_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NCH     = 4,
  parameter int SELW    = clog2_nch(NCH),
  parameter int RR_MODE = ARB_RR
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arb_mux_if.slave  bus
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_sel_q, out_sel_d;
  logic [NCH-1:0]   gnt;
  logic [SELW-1:0]  gnt_idx;
  logic             load;
  logic             take;

  assign load = ~out_valid_q | bus.out_ready;
  assign take = load & (|bus.in_valid) & ~reset;

  rr_arbiter #(
    .NCH     (NCH),
    .SELW    (SELW),
    .RR_MODE (RR_MODE)
  ) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (bus.in_valid),
    .take    (take),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign bus.in_ready  = take ? gnt : '0;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    if (take) begin
      out_valid_d = 1'b1;
      out_data_d  = bus.in_data[lane_lo(int'(gnt_idx), WIDTH) +: WIDTH];
      out_sel_d   = gnt_idx;
    end else if (load) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arb_mux.sv
// Directed bench: expected words queued at grant time, popped by
// per-DUT monitors on every downstream acceptance.
module tb_mem_port_arb_mux;

  localparam int W = 32;
  localparam int N = 4;
  localparam int S = 2;

  logic clk;
  logic reset;

  mem_port_arb_mux_if #(.WIDTH(W), .NCH(N), .SELW(S)) b_rr ();
  mem_port_arb_mux_if #(.WIDTH(W), .NCH(N), .SELW(S)) b_fx ();

  mem_port_arb_mux #(
    .WIDTH(W), .NCH(N), .SELW(S), .RR_MODE(1)
  ) u_rr (
    .clk   (clk),
    .reset (reset),
    .bus   (b_rr)
  );

  mem_port_arb_mux #(
    .WIDTH(W), .NCH(N), .SELW(S), .RR_MODE(0)
  ) u_fx (
    .clk   (clk),
    .reset (reset),
    .bus   (b_fx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [W-1:0]   chdata [N];
  logic [S+W-1:0] q_rr [$];
  logic [S+W-1:0] q_fx [$];

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitors: a word leaves on any edge with out_valid && out_ready.
  always @(negedge clk) begin
    if (!reset && b_rr.out_valid && b_rr.out_ready) begin
      if (q_rr.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rr_unexpected actual=%h required=none",
                 {b_rr.out_sel, b_rr.out_data});
      end else begin
        chk("rr_word", {30'd0, b_rr.out_sel, b_rr.out_data},
            {30'd0, q_rr.pop_front()});
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && b_fx.out_valid && b_fx.out_ready) begin
      if (q_fx.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL fx_unexpected actual=%h required=none",
                 {b_fx.out_sel, b_fx.out_data});
      end else begin
        chk("fx_word", {30'd0, b_fx.out_sel, b_fx.out_data},
            {30'd0, q_fx.pop_front()});
      end
    end
  end

  function automatic logic [S-1:0] oh2idx(input logic [N-1:0] oh);
    logic [S-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) if (oh[i]) r = S'(i);
    return r;
  endfunction

  // One cycle: drive at posedge+1, check in_ready at negedge.
  task automatic step(input bit fx, input bit rst,
                      input logic [N-1:0] v, input bit ordy,
                      input logic [N-1:0] exp_rdy);
    logic [N*W-1:0] flat;
    logic [S-1:0]   gi;
    flat = '0;
    for (int i = 0; i < N; i++) flat[i*W +: W] = chdata[i];
    reset          = rst;
    b_rr.in_data   = flat;
    b_fx.in_data   = flat;
    b_rr.in_valid  = fx ? '0 : v;
    b_fx.in_valid  = fx ? v : '0;
    b_rr.out_ready = fx ? 1'b1 : ordy;
    b_fx.out_ready = fx ? ordy : 1'b1;
    if (exp_rdy != '0 && !rst) begin
      gi = oh2idx(exp_rdy);
      if (fx) q_fx.push_back({gi, chdata[gi]});
      else    q_rr.push_back({gi, chdata[gi]});
    end
    @(negedge clk);
    if (fx) chk("fx_in_ready", 64'(b_fx.in_ready), 64'(exp_rdy));
    else    chk("rr_in_ready", 64'(b_rr.in_ready), 64'(exp_rdy));
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    b_rr.in_valid = '0; b_rr.in_data = '0; b_rr.out_ready = 1'b1;
    b_fx.in_valid = '0; b_fx.in_data = '0; b_fx.out_ready = 1'b1;
    for (int i = 0; i < N; i++) chdata[i] = 32'hA0A0_0000 + i;
    @(posedge clk);
    #1;

    // Reset with every channel requesting.
    for (int c = 0; c < 2; c++) begin
      reset = 1'b1;
      b_rr.in_valid = 4'b1111;
      b_fx.in_valid = 4'b1111;
      @(negedge clk);
      chk("rst_rr_in_ready", 64'(b_rr.in_ready), 64'd0);
      chk("rst_fx_in_ready", 64'(b_fx.in_ready), 64'd0);
      chk("rst_out_valid", 64'(b_rr.out_valid), 64'd0);
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    b_rr.in_valid = '0;
    b_fx.in_valid = '0;
    @(negedge clk);
    chk("rst_out_data", 64'(b_rr.out_data), 64'd0);
    chk("rst_out_sel", 64'(b_rr.out_sel), 64'd0);
    chk("rst_fx_valid", 64'(b_fx.out_valid), 64'd0);
    @(posedge clk);
    #1;

    // Single channel 2 at ptr 0; ptr -> 3.
    chdata[2] = 32'hDEAD_BEEF;
    step(0, 0, 4'b0100, 1, 4'b0100);
    step(0, 0, 4'b0000, 1, 4'b0000);

    // Wrap: ptr 3, ch0+ch1 -> ch0 (ptr 1), then ch1 (ptr 2).
    step(0, 0, 4'b0011, 1, 4'b0001);
    step(0, 0, 4'b0011, 1, 4'b0010);
    // Lone ch3 at ptr 2 -> ptr 0.
    step(0, 0, 4'b1000, 1, 4'b1000);

    // Fairness: 0,1,2,3,0,1 back to back; ptr ends at 2.
    step(0, 0, 4'b1111, 1, 4'b0001);
    step(0, 0, 4'b1111, 1, 4'b0010);
    step(0, 0, 4'b1111, 1, 4'b0100);
    step(0, 0, 4'b1111, 1, 4'b1000);
    step(0, 0, 4'b1111, 1, 4'b0001);
    step(0, 0, 4'b1111, 1, 4'b0010);
    step(0, 0, 4'b0000, 1, 4'b0000);

    // Backpressure: ch1 held 3 cycles while ch3 waits.
    step(0, 0, 4'b0010, 1, 4'b0010);
    for (int c = 0; c < 3; c++) begin
      step(0, 0, 4'b1000, 0, 4'b0000);
      chk("stall_sel", 64'(b_rr.out_sel), 64'd1);
      chk("stall_data", 64'(b_rr.out_data), 64'(chdata[1]));
      chk("stall_valid", 64'(b_rr.out_valid), 64'd1);
    end
    step(0, 0, 4'b1000, 1, 4'b1000);
    step(0, 0, 4'b0000, 1, 4'b0000);

    // Mid-operation reset discards a held word; ptr 1 -> 0.
    step(0, 0, 4'b0001, 1, 4'b0001);
    step(0, 0, 4'b0000, 0, 4'b0000);
    step(0, 1, 4'b0100, 0, 4'b0000);
    q_rr.delete();
    chk("midrst_valid", 64'(b_rr.out_valid), 64'd0);
    step(0, 0, 4'b0011, 1, 4'b0001);
    step(0, 0, 4'b0000, 1, 4'b0000);

    // Fixed priority: lowest index always wins.
    step(1, 0, 4'b1111, 1, 4'b0001);
    step(1, 0, 4'b1111, 1, 4'b0001);
    step(1, 0, 4'b1111, 1, 4'b0001);
    step(1, 0, 4'b1111, 1, 4'b0001);
    step(1, 0, 4'b1100, 1, 4'b0100);
    step(1, 0, 4'b1010, 1, 4'b0010);
    step(1, 0, 4'b0000, 1, 4'b0000);
    step(1, 0, 4'b0000, 1, 4'b0000);

    chk("rr_queue_empty", 64'(q_rr.size()), 64'd0);
    chk("fx_queue_empty", 64'(q_fx.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
